kbd_port: RTL and testbench

PS/2 keyboard responder: the peripheral end of the controller's IN instruction handshake (`kbd_trigger_en` / `kbd_out_en`). It deserializes PS/2 device-to-host frames and buffers the scancode bytes in a small FIFO. It pops one byte per IN instruction and drives the byte onto the 16-bit data bus only while `kbd_out_en` is high. It sits beside the display port on the shared bus and is clocked by the CPU clock.

---
 rtl/kbd_pkg.sv | 15 +
 rtl/ps2_rx.sv | 94 +++++++++
 rtl/kbd_port.sv | 105 ++++++++++
 tb/tb_kbd_port.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard responder.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int FRAME_LEN = 11;
    localparam int VALID_BIT = 8;
    localparam int OVF_BIT   = 9;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host deserializer: 2-FF sync, falling-edge sampling, odd parity, timeout.
// Byte strobe is registered one cycle after the stop bit is sampled; no backpressure.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_vld,
    output logic [7:0] o_byte
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_clk_prev;
    rx_state_t     r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tmo;

    logic w_fall;
    logic w_bit;

    assign w_fall = ~r_clk_sync[1] & r_clk_prev;
    assign w_bit  = r_dat_sync[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
            r_state    <= IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_par      <= 1'b0;
            r_tmo      <= '0;
            o_byte_vld <= 1'b0;
            o_byte     <= 8'd0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
            r_clk_prev <= r_clk_sync[1];
            o_byte_vld <= 1'b0;
            if (w_fall) begin
                r_tmo <= '0;
                case (r_state)
                    IDLE: begin
                        if (!w_bit) begin
                            r_state   <= DATA;
                            r_bit_cnt <= 3'd0;
                            r_par     <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_par     <= r_par ^ w_bit;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_par   <= r_par ^ w_bit;
                        r_state <= STOP;
                    end
                    default: begin
                        // r_par now holds the XOR of data and parity: 1 means odd count of ones
                        if (w_bit && r_par) begin
                            o_byte_vld <= 1'b1;
                            o_byte     <= r_shift;
                        end
                        r_state <= IDLE;
                    end
                endcase
            end else if (r_state != IDLE) begin
                if (r_tmo == TW'(TIMEOUT - 1)) begin
                    r_state <= IDLE;
                    r_tmo   <= '0;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end

endmodule

// File: rtl/kbd_port.sv
// IN-port keyboard responder: PS/2 bytes buffered in a FIFO, one pop per trigger rising edge.
// Read word valid 1 cycle after trigger edge; bus is combinational on out_en; FIFO overflow drops and flags.
module kbd_port
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        kbd_trigger_en,
    input  logic        kbd_out_en,
    output logic        kbd_avail,
    output logic [15:0] out
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic          w_rx_vld;
    logic [7:0]    w_rx_byte;
    logic          w_trig_rise;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [15:0]   w_rd_word;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_trig_prev;
    logic [15:0]   r_rd_reg;

    ps2_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_byte_vld (w_rx_vld),
        .o_byte     (w_rx_byte)
    );

    assign w_trig_rise = kbd_trigger_en & ~r_trig_prev;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop       = w_trig_rise & ~w_empty;
    // A simultaneous pop frees the slot, so a push while full is kept in that case
    assign w_push      = w_rx_vld & (~w_full | w_pop);

    always_comb begin
        w_rd_word            = 16'h0000;
        w_rd_word[7:0]       = r_mem[r_rd_ptr];
        w_rd_word[VALID_BIT] = 1'b1;
        w_rd_word[OVF_BIT]   = r_ovf;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_trig_prev <= 1'b0;
            r_rd_reg    <= 16'h0000;
        end else begin
            r_trig_prev <= kbd_trigger_en;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rx_vld && !w_push) begin
                r_ovf <= 1'b1;
            end
            if (w_trig_rise) begin
                if (w_pop) begin
                    r_rd_reg <= w_rd_word;
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                    r_ovf    <= 1'b0;
                end else begin
                    r_rd_reg <= 16'h0000;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign kbd_avail = ~w_empty;
    assign out       = kbd_out_en ? r_rd_reg : 16'h0000;

endmodule

// File: tb/tb_kbd_port.sv
// Randomized bench for kbd_port against a queue-based model of the scancode buffer.
module tb_kbd_port;
    import kbd_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        kbd_trigger_en = 1'b0;
    logic        kbd_out_en = 1'b0;
    logic        kbd_avail;
    logic [15:0] out;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;

    kbd_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .kbd_trigger_en (kbd_trigger_en),
        .kbd_out_en     (kbd_out_en),
        .kbd_avail      (kbd_avail),
        .out            (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Sends the first nbits of a frame; a frame counts only with odd parity and stop=1.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int nbits, input int half);
        logic [FRAME_LEN-1:0] bits;
        bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (half + 6) @(negedge clk);
        ps2_data = 1'b1;
        if (nbits == FRAME_LEN && !bad_par && !bad_stop) begin
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(d);
        end
    endtask

    task automatic do_read(input string tag, input int hold);
        logic [15:0] exp;
        @(negedge clk) kbd_trigger_en = 1'b1;
        repeat (hold) @(negedge clk);
        kbd_trigger_en = 1'b0;
        if (m_q.size() != 0) begin
            exp = {6'b0, m_ovf, 1'b1, m_q.pop_front()};
            m_ovf = 1'b0;
        end else begin
            exp = 16'h0000;
        end
        repeat (2) @(negedge clk);
        check({tag, "/idle"}, out, 16'h0000);
        kbd_out_en = 1'b1;
        #1 check({tag, "/out"}, out, exp);
        check({tag, "/avail"}, {15'b0, kbd_avail}, {15'b0, m_q.size() != 0});
        @(negedge clk) kbd_out_en = 1'b0;
        #1 check({tag, "/off"}, out, 16'h0000);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        kbd_out_en = 1'b1;
        #1 check("reset_out", out, 16'h0000);
        check("reset_avail", {15'b0, kbd_avail}, 16'h0000);
        @(negedge clk) kbd_out_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(8'h1C, 0, 0, FRAME_LEN, 5);
        check("good_avail", {15'b0, kbd_avail}, 16'h0001);
        do_read("good", 4);
        check("good_val", 16'h011C, 16'h011C & {16{m_q.size() == 0}});

        send_frame(8'h1C, 1, 0, FRAME_LEN, 5);
        check("badpar_avail", {15'b0, kbd_avail}, 16'h0000);
        do_read("badpar", 4);

        for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 0, 0, FRAME_LEN, 4);
        check("ovf_depth", 16'(m_q.size()), 16'(DEPTH));
        do_read("ovf1", 4);
        do_read("ovf2", 4);
        while (m_q.size() != 0) do_read("drain", 3);

        send_frame(8'h00, 0, 0, 4, 5);
        repeat (TMO + 10) @(negedge clk);
        send_frame(8'h5A, 0, 0, FRAME_LEN, 5);
        do_read("timeout", 4);

        send_frame(8'h31, 0, 0, FRAME_LEN, 5);
        send_frame(8'h32, 0, 0, FRAME_LEN, 5);
        send_frame(8'h33, 0, 0, 5, 5);
        @(negedge clk) rst = 1'b0;
        ps2_clk = 1'b1;
        repeat (2) @(negedge clk);
        kbd_out_en = 1'b1;
        #1 check("rst_out", out, 16'h0000);
        check("rst_avail", {15'b0, kbd_avail}, 16'h0000);
        @(negedge clk) kbd_out_en = 1'b0;
        rst = 1'b1;
        m_q.delete();
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(8'h2B, 0, 0, FRAME_LEN, 5);
        do_read("post_rst", 4);

        send_frame(8'h41, 0, 0, FRAME_LEN, 5);
        send_frame(8'h42, 0, 0, FRAME_LEN, 5);
        do_read("hold20", 20);
        check("hold20_left", 16'(m_q.size()), 16'd1);
        do_read("hold20_b", 4);
        do_read("hold20_c", 4);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) != 0)
                send_frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                           FRAME_LEN, $urandom_range(4, 7));
            else
                do_read("rand", $urandom_range(1, 8));
        end
        while (m_q.size() != 0) do_read("rand_drain", 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
